reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   In-order retirement buffer for the o3cpu. Allocates one entry per dispatched
//   instruction; the entry index is handed to the rename table as the pending
//   tag. Writes results back from execution and serves operand reads by tag.
//   Retires the head entry, driving the rename-table commit port (we/addr/data/index),
//   and raises a one-cycle rollback pulse after a mispredicted entry retires.
// PARAMETERS
//   ENTRY_W  3  index width; DEPTH = 2**ENTRY_W entries; equals `ROB_ENTRY_WIDTH
// PORTS
//   clk            in   1        clock, all state on posedge
//   rst            in   1        reset, asynchronous, active-high
//   alloc_valid    in   1        dispatch requests an entry this cycle
//   alloc_ready    out  1        buffer not full; alloc accepted iff valid&ready
//   alloc_dst      in   5        destination arch reg (0 = no register write)
//   alloc_index    out  ENTRY_W  index that the accepted alloc receives (tail)
//   wb_valid       in   1        execution result valid
//   wb_index       in   ENTRY_W  entry being written back
//   wb_data        in   32       result value
//   wb_mispredict  in   1        entry is a mispredicted control transfer
//   rd_index1/2    in   ENTRY_W  operand tag lookup
//   rd_ready1/2    out  1        tagged value available
//   rd_data1/2     out  32       tagged value
//   commit_we      out  1        write arch reg this cycle
//   commit_addr    out  5        arch reg of retiring entry
//   commit_data    out  32       value of retiring entry
//   commit_index   out  ENTRY_W  index of retiring entry
//   rollback       out  1        flush pulse to rename table and front end
//   count          out  ENTRY_W+1 occupied entries
//   empty          out  1        count == 0
// BEHAVIOUR
// - Per entry: busy, ready, mispred, dst[4:0], value[31:0]. head/tail are
//   ENTRY_W+1 bits (MSB = wrap). empty: head==tail; full: low bits equal, MSBs differ.
// - Reset (async): all busy/ready/mispred=0, head=tail=0, rb_pend=0. Outputs:
//   alloc_ready=1, alloc_index=0, commit_we=0, rollback=0, count=0, empty=1, rd_ready*=0.
// - Alloc: on valid&ready, entry[tail]: busy=1, ready=0, mispred=0, dst latched; tail+1.
//   alloc_index = tail[ENTRY_W-1:0], combinational. alloc_ready = !full && !rollback
//   (does not account for a same-cycle retire; stays conservative).
// - Writeback: if wb_valid and entry[wb_index].busy: ready=1, value=wb_data,
//   mispred=wb_mispredict. Writeback to a non-busy entry is ignored.
// - Retire (combinational decision): retire = entry[head].busy & ready & !rollback.
//   commit_index=head, commit_addr=dst, commit_data=value, commit_we = retire & dst!=0.
//   On the edge: busy[head]=0, head+1. An entry written back in cycle N retires in N+1 at earliest.
//   dst==0 entries retire with commit_we=0 (head still advances).
// - Mispredict: retiring entry with mispred=1 still commits its value (commit_we per dst),
//   and sets rb_pend. rollback = rb_pend (registered, exactly 1 cycle). While rollback=1:
//   no retire, no alloc, writebacks ignored. On that edge: all busy=0, head=tail=0, rb_pend=0.
// - Read ports: rd_ready = busy & ready of entry; rd_data = value. Same-cycle bypass:
//   wb_valid & wb_index==rd_index & busy -> rd_ready=1, rd_data=wb_data.
//   Non-busy entry -> rd_ready=0, rd_data=0.
// - count = tail - head (ENTRY_W+1 bits, modular); max DEPTH. Wrap handled by pointer MSB.
// - Simultaneous alloc+retire when not full: both happen, count unchanged.
// - Reset mid-operation: state cleared immediately, independent of clk; in-flight entries lost.
// TESTING
// 1 Alloc dst 1,2,3 -> alloc_index 0,1,2, count=3; wb idx1=0xAA: no commit; wb idx0=0x11
//   -> next cycle commit_we=1 addr=1 data=0x11 index=0; following cycle addr=2 data=0xAA index=1.
// 2 Alloc 8 (DEPTH=8) -> alloc_ready=0, count=8; 9th request ignored; retire one ->
//   alloc_ready=1, alloc_index=0 (wrap), count returns to 8 after alloc.
// 3 Alloc 4 (idx0 dst=5); wb idx1..3, then idx0 data=0x40 mispredict=1 -> commit_we addr=5
//   data=0x40; next cycle rollback=1 for one cycle; then count=0, empty=1, alloc_index=0; idx1..3 never commit.
// 4 Alloc dst=0, wb -> retire with commit_we=0, count decrements, head advances.
// 5 rd_index1=2 with wb_valid wb_index=2 wb_data=0x55 same cycle (entry busy) ->
//   rd_ready1=1, rd_data1=0x55; rd_index2 on empty entry -> rd_ready2=0.
// 6 Assert rst between edges with 5 entries live -> count=0, empty=1, commit_we=0, rollback=0 at once.

Source files
------------

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement buffer for the o3cpu. Dispatch allocates one entry per
// instruction at the tail; the entry index doubles as the pending rename tag.
// Execution writes results back by index, operand lookups read by tag, and the
// head entry retires in program order once its result is ready, driving the
// rename-table commit port. When a mispredicted entry retires, a one-cycle
// rollback pulse follows which flushes every in-flight entry.
//
// Ports
//   clk, rst                   clock (posedge) / async active-high reset
//   alloc_valid/ready          dispatch handshake; accepted iff valid & ready
//   alloc_dst                  destination arch reg (0 = no register write)
//   alloc_index                tail index the accepted alloc receives
//   wb_valid/index/data        execution result writeback
//   wb_mispredict              written-back entry is a mispredicted branch
//   rd_index1/2                operand tag lookups
//   rd_ready1/2, rd_data1/2    tagged value present / value (same-cycle bypass)
//   commit_we/addr/data/index  rename-table commit port for the retiring entry
//   rollback                   one-cycle flush pulse
//   count, empty               occupancy
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ENTRY_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [4:0]         alloc_dst,
    output logic [ENTRY_W-1:0] alloc_index,
    input  logic               wb_valid,
    input  logic [ENTRY_W-1:0] wb_index,
    input  logic [31:0]        wb_data,
    input  logic               wb_mispredict,
    input  logic [ENTRY_W-1:0] rd_index1,
    output logic               rd_ready1,
    output logic [31:0]        rd_data1,
    input  logic [ENTRY_W-1:0] rd_index2,
    output logic               rd_ready2,
    output logic [31:0]        rd_data2,
    output logic               commit_we,
    output logic [4:0]         commit_addr,
    output logic [31:0]        commit_data,
    output logic [ENTRY_W-1:0] commit_index,
    output logic               rollback,
    output logic [ENTRY_W:0]   count,
    output logic               empty
);

    localparam int DEPTH = 1 << ENTRY_W;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [ENTRY_W:0]   ptr_t;
    typedef logic [ENTRY_W-1:0] idx_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DEPTH-1:0] busy_q,    busy_d;
    logic [DEPTH-1:0] ready_q,   ready_d;
    logic [DEPTH-1:0] mispred_q, mispred_d;
    logic [4:0]       dst_q   [DEPTH];
    logic [4:0]       dst_d   [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [31:0]      value_d [DEPTH];
    ptr_t             head_q,    head_d;
    ptr_t             tail_q,    tail_d;
    logic             rb_pend_q, rb_pend_d;

    // ---------------------------------------------------------------------
    // Derived status
    // ---------------------------------------------------------------------
    idx_t head_idx;
    idx_t tail_idx;
    logic full;
    logic alloc_fire;
    logic wb_fire;
    logic retire;

    assign head_idx = head_q[ENTRY_W-1:0];
    assign tail_idx = tail_q[ENTRY_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[ENTRY_W] != tail_q[ENTRY_W]);
    assign empty    = (head_q == tail_q);
    assign count    = tail_q - head_q;

    assign rollback    = rb_pend_q;
    // Conservative: a retire in the same cycle does not open a slot early.
    assign alloc_ready = !full && !rollback;
    assign alloc_index = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Writebacks to free entries are stale (e.g. after a flush) and dropped.
    assign wb_fire = wb_valid && busy_q[wb_index] && !rollback;

    // Retire looks only at registered ready, so a result written back in
    // cycle N is first eligible to retire in cycle N+1.
    assign retire = busy_q[head_idx] && ready_q[head_idx] && !rollback;

    // ---------------------------------------------------------------------
    // Commit port
    // ---------------------------------------------------------------------
    assign commit_index = head_idx;
    assign commit_addr  = dst_q[head_idx];
    assign commit_data  = value_q[head_idx];
    assign commit_we    = retire && (dst_q[head_idx] != 5'd0);

    // ---------------------------------------------------------------------
    // Operand read ports with same-cycle writeback bypass
    // ---------------------------------------------------------------------
    always_comb begin
        rd_ready1 = 1'b0;
        rd_data1  = 32'd0;
        if (busy_q[rd_index1]) begin
            if (wb_fire && (wb_index == rd_index1)) begin
                rd_ready1 = 1'b1;
                rd_data1  = wb_data;
            end else begin
                rd_ready1 = ready_q[rd_index1];
                rd_data1  = value_q[rd_index1];
            end
        end
    end

    always_comb begin
        rd_ready2 = 1'b0;
        rd_data2  = 32'd0;
        if (busy_q[rd_index2]) begin
            if (wb_fire && (wb_index == rd_index2)) begin
                rd_ready2 = 1'b1;
                rd_data2  = wb_data;
            end else begin
                rd_ready2 = ready_q[rd_index2];
                rd_data2  = value_q[rd_index2];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a default from its _q first, so paths that do
        // not touch a signal hold it instead of inferring a latch.
        busy_d    = busy_q;
        ready_d   = ready_q;
        mispred_d = mispred_q;
        dst_d     = dst_q;
        value_d   = value_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rb_pend_d = rb_pend_q;

        if (rollback) begin
            // Flush edge: every in-flight entry is squashed, pointers restart.
            busy_d    = '0;
            head_d    = '0;
            tail_d    = '0;
            rb_pend_d = 1'b0;
        end else begin
            if (wb_fire) begin
                ready_d[wb_index]   = 1'b1;
                value_d[wb_index]   = wb_data;
                mispred_d[wb_index] = wb_mispredict;
            end

            if (retire) begin
                busy_d[head_idx] = 1'b0;
                head_d           = head_q + ptr_t'(1);
                // The mispredicted entry still commits; the flush follows.
                if (mispred_q[head_idx]) begin
                    rb_pend_d = 1'b1;
                end
            end

            // Tail never aliases a busy entry, so this cannot clash with the
            // writeback or retire updates above.
            if (alloc_fire) begin
                busy_d[tail_idx]    = 1'b1;
                ready_d[tail_idx]   = 1'b0;
                mispred_d[tail_idx] = 1'b0;
                dst_d[tail_idx]     = alloc_dst;
                tail_d              = tail_q + ptr_t'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            ready_q   <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rb_pend_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            mispred_q <= mispred_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rb_pend_q <= rb_pend_d;
        end
    end

    // NOTE: the payload arrays are deliberately not reset; an entry's dst and
    // value are only observed while its busy bit is set, and alloc/writeback
    // always write them before that, so they can map to plain RAM.
    always_ff @(posedge clk) begin
        dst_q   <= dst_d;
        value_q <= value_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed self-checking bench for reorder_buffer (ENTRY_W = 3, DEPTH = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later,
// well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int ENTRY_W = 3;
    localparam int DEPTH   = 8;

    logic               clk;
    logic               rst;
    logic               alloc_valid;
    logic               alloc_ready;
    logic [4:0]         alloc_dst;
    logic [ENTRY_W-1:0] alloc_index;
    logic               wb_valid;
    logic [ENTRY_W-1:0] wb_index;
    logic [31:0]        wb_data;
    logic               wb_mispredict;
    logic [ENTRY_W-1:0] rd_index1;
    logic               rd_ready1;
    logic [31:0]        rd_data1;
    logic [ENTRY_W-1:0] rd_index2;
    logic               rd_ready2;
    logic [31:0]        rd_data2;
    logic               commit_we;
    logic [4:0]         commit_addr;
    logic [31:0]        commit_data;
    logic [ENTRY_W-1:0] commit_index;
    logic               rollback;
    logic [ENTRY_W:0]   count;
    logic               empty;

    int total  = 0;
    int passed = 0;

    reorder_buffer #(.ENTRY_W(ENTRY_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_dst    (alloc_dst),
        .alloc_index  (alloc_index),
        .wb_valid     (wb_valid),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .wb_mispredict(wb_mispredict),
        .rd_index1    (rd_index1),
        .rd_ready1    (rd_ready1),
        .rd_data1     (rd_data1),
        .rd_index2    (rd_index2),
        .rd_ready2    (rd_ready2),
        .rd_data2     (rd_data2),
        .commit_we    (commit_we),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .commit_index (commit_index),
        .rollback     (rollback),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs may be changed afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid   = 1'b0;
        alloc_dst     = 5'd0;
        wb_valid      = 1'b0;
        wb_index      = '0;
        wb_data       = 32'd0;
        wb_mispredict = 1'b0;
        rd_index1     = '0;
        rd_index2     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input logic [4:0] dst);
        alloc_valid = 1'b1;
        alloc_dst   = dst;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic wb_one(input int idx, input logic [31:0] data, input logic misp);
        wb_valid      = 1'b1;
        wb_index      = idx[ENTRY_W-1:0];
        wb_data       = data;
        wb_mispredict = misp;
        step();
        wb_valid      = 1'b0;
        wb_mispredict = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); else passed++;
        total++; if (alloc_index !== 3'd0) $display("FAIL reset_alloc_index got %0d exp 0", alloc_index); else passed++;
        total++; if (commit_we !== 1'b0) $display("FAIL reset_commit_we got %0b exp 0", commit_we); else passed++;
        total++; if (rollback !== 1'b0) $display("FAIL reset_rollback got %0b exp 0", rollback); else passed++;
        total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", empty); else passed++;
        total++; if (rd_ready1 !== 1'b0 || rd_ready2 !== 1'b0) $display("FAIL reset_rd_ready got %0b%0b exp 00", rd_ready1, rd_ready2); else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (alloc_index !== 3'(i)) $display("FAIL inord_alloc_index got %0d exp %0d", alloc_index, i); else passed++;
            alloc_one(5'(i + 1));
        end
        total++; if (count !== 4'd3) $display("FAIL inord_count got %0d exp 3", count); else passed++;
        wb_one(1, 32'hAA, 1'b0);
        total++; if (commit_we !== 1'b0) $display("FAIL inord_no_commit got %0b exp 0", commit_we); else passed++;
        wb_valid = 1'b1; wb_index = 3'd0; wb_data = 32'h11;
        #1;
        total++; if (commit_we !== 1'b0) $display("FAIL inord_same_cycle_wb got %0b exp 0", commit_we); else passed++;
        step();
        wb_valid = 1'b0;
        #1;
        total++; if ({commit_we, commit_addr, commit_data, commit_index} !== {1'b1, 5'd1, 32'h11, 3'd0})
            $display("FAIL inord_commit0 got we=%0b a=%0d d=%h i=%0d exp we=1 a=1 d=11 i=0", commit_we, commit_addr, commit_data, commit_index);
        else passed++;
        step();
        total++; if ({commit_we, commit_addr, commit_data, commit_index} !== {1'b1, 5'd2, 32'hAA, 3'd1})
            $display("FAIL inord_commit1 got we=%0b a=%0d d=%h i=%0d exp we=1 a=2 d=aa i=1", commit_we, commit_addr, commit_data, commit_index);
        else passed++;
        step();
        total++; if (commit_we !== 1'b0 || count !== 4'd1) $display("FAIL inord_after got we=%0b cnt=%0d exp we=0 cnt=1", commit_we, count); else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc_one(5'(i + 1));
        total++; if (alloc_ready !== 1'b0 || count !== 4'd8) $display("FAIL full_state got rdy=%0b cnt=%0d exp rdy=0 cnt=8", alloc_ready, count); else passed++;
        alloc_one(5'd20);   // refused: buffer full
        total++; if (count !== 4'd8 || alloc_index !== 3'd0) $display("FAIL full_ignore got cnt=%0d idx=%0d exp cnt=8 idx=0", count, alloc_index); else passed++;
        wb_one(0, 32'h1234, 1'b0);
        total++; if ({commit_we, commit_addr, commit_index} !== {1'b1, 5'd1, 3'd0})
            $display("FAIL full_retire got we=%0b a=%0d i=%0d exp we=1 a=1 i=0", commit_we, commit_addr, commit_index);
        else passed++;
        total++; if (alloc_ready !== 1'b0) $display("FAIL full_conservative got %0b exp 0", alloc_ready); else passed++;
        step();
        total++; if (alloc_ready !== 1'b1 || alloc_index !== 3'd0 || count !== 4'd7)
            $display("FAIL full_wrap got rdy=%0b idx=%0d cnt=%0d exp rdy=1 idx=0 cnt=7", alloc_ready, alloc_index, count);
        else passed++;
        alloc_one(5'd9);
        total++; if (count !== 4'd8 || alloc_ready !== 1'b0) $display("FAIL full_refill got cnt=%0d rdy=%0b exp cnt=8 rdy=0", count, alloc_ready); else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(5'(i + 5));
        for (int i = 1; i < 4; i++) wb_one(i, 32'h100 + 32'(i), 1'b0);
        wb_one(0, 32'h40, 1'b1);
        total++; if ({commit_we, commit_addr, commit_data, commit_index, rollback} !== {1'b1, 5'd5, 32'h40, 3'd0, 1'b0})
            $display("FAIL mp_commit got we=%0b a=%0d d=%h i=%0d rb=%0b exp we=1 a=5 d=40 i=0 rb=0", commit_we, commit_addr, commit_data, commit_index, rollback);
        else passed++;
        step();
        total++; if (rollback !== 1'b1 || commit_we !== 1'b0 || alloc_ready !== 1'b0)
            $display("FAIL mp_pulse got rb=%0b we=%0b rdy=%0b exp rb=1 we=0 rdy=0", rollback, commit_we, alloc_ready);
        else passed++;
        step();
        total++; if ({rollback, count, empty, alloc_index, commit_we} !== {1'b0, 4'd0, 1'b1, 3'd0, 1'b0})
            $display("FAIL mp_flushed got rb=%0b cnt=%0d emp=%0b idx=%0d we=%0b exp rb=0 cnt=0 emp=1 idx=0 we=0", rollback, count, empty, alloc_index, commit_we);
        else passed++;
        step();
        total++; if (commit_we !== 1'b0 || rollback !== 1'b0) $display("FAIL mp_quiet got we=%0b rb=%0b exp 0 0", commit_we, rollback); else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_no_dst();
        do_reset();
        alloc_one(5'd0);
        wb_one(0, 32'hDEAD, 1'b0);
        total++; if (commit_we !== 1'b0 || commit_index !== 3'd0 || count !== 4'd1)
            $display("FAIL nodst_retire got we=%0b i=%0d cnt=%0d exp we=0 i=0 cnt=1", commit_we, commit_index, count);
        else passed++;
        step();
        total++; if (count !== 4'd0 || empty !== 1'b1 || alloc_index !== 3'd1)
            $display("FAIL nodst_advance got cnt=%0d emp=%0b idx=%0d exp cnt=0 emp=1 idx=1", count, empty, alloc_index);
        else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(5'(i + 1));
        rd_index1 = 3'd2;
        rd_index2 = 3'd5;
        #1;
        total++; if (rd_ready1 !== 1'b0) $display("FAIL byp_pending got %0b exp 0", rd_ready1); else passed++;
        wb_valid = 1'b1; wb_index = 3'd2; wb_data = 32'h55;
        #1;
        total++; if (rd_ready1 !== 1'b1 || rd_data1 !== 32'h55) $display("FAIL byp_same_cycle got rdy=%0b d=%h exp rdy=1 d=55", rd_ready1, rd_data1); else passed++;
        total++; if (rd_ready2 !== 1'b0 || rd_data2 !== 32'd0) $display("FAIL byp_free_entry got rdy=%0b d=%h exp rdy=0 d=0", rd_ready2, rd_data2); else passed++;
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (rd_ready1 !== 1'b1 || rd_data1 !== 32'h55 || commit_we !== 1'b0)
            $display("FAIL byp_stored got rdy=%0b d=%h we=%0b exp rdy=1 d=55 we=0", rd_ready1, rd_data1, commit_we);
        else passed++;
        wb_valid = 1'b1; wb_index = 3'd6; wb_data = 32'h77;   // free entry: dropped
        step();
        wb_valid = 1'b0;
        rd_index2 = 3'd6;
        #1;
        total++; if (rd_ready2 !== 1'b0 || count !== 4'd3) $display("FAIL byp_stale_wb got rdy=%0b cnt=%0d exp rdy=0 cnt=3", rd_ready2, count); else passed++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(5'(i + 1));
        wb_one(0, 32'h99, 1'b0);
        total++; if (commit_we !== 1'b1 || count !== 4'd5) $display("FAIL arst_before got we=%0b cnt=%0d exp we=1 cnt=5", commit_we, count); else passed++;
        #1;
        rst = 1'b1;   // between edges
        #1;
        total++; if ({count, empty, commit_we, rollback} !== {4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL arst_immediate got cnt=%0d emp=%0b we=%0b rb=%0b exp cnt=0 emp=1 we=0 rb=0", count, empty, commit_we, rollback);
        else passed++;
        step();
        rst = 1'b0;
        #1;
        total++; if (alloc_ready !== 1'b1 || alloc_index !== 3'd0) $display("FAIL arst_after got rdy=%0b idx=%0d exp rdy=1 idx=0", alloc_ready, alloc_index); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_no_dst();
        test_bypass();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
